// File: rtl/uart_rx_pkg.sv
// Shared widths and defaults for the UART receive-side buffer.
package uart_rx_pkg;
    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 8;
    localparam int ERR_CNT_W  = 8;
endpackage

// File: rtl/uart_rx_fifo_if.sv
// Host-side read port of the receive FIFO: head byte with valid/ready handshake.
interface uart_rx_fifo_if import uart_rx_pkg::*; ();
    logic [DATA_W-1:0] RD_DATA;
    logic              RD_VALID;
    logic              RD_READY;

    modport master (output RD_DATA, output RD_VALID, input RD_READY);
    modport slave  (input RD_DATA, input RD_VALID, output RD_READY);
endinterface

// File: rtl/uart_rx_fifo_err_event_cnt.sv
// Counts rising edges of a level error flag into a saturating counter; clear wins.
// Latency: count updates on the edge after the flag rises; no backpressure.
module err_event_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flag,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);
    logic flag_q;
    logic evt;

    assign evt = flag & ~flag_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_q <= 1'b0;
            cnt    <= '0;
        end else begin
            flag_q <= flag;
            if (clr)
                cnt <= '0;
            else if (evt && (cnt != {CNT_W{1'b1}}))
                cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// FWFT byte FIFO behind the UART receiver plus overflow and error-event status.
// Latency: byte visible right after its push edge; full drops bytes unless a pop frees space.
module uart_rx_fifo import uart_rx_pkg::*; #(
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = ERR_CNT_W
) (
    input  logic              clk_RX,
    input  logic              rst,
    input  logic [DATA_W-1:0] P_DATA,
    input  logic              data_Valid,
    input  logic              Parity_Error,
    input  logic              Stop_Error,
    uart_rx_fifo_if.master    rd,
    output logic [ADDR_W:0]   FIFO_COUNT,
    output logic              FULL,
    output logic              OVERFLOW,
    input  logic              clr_ovf,
    output logic [CNT_W-1:0]  PAR_ERR_CNT,
    output logic [CNT_W-1:0]  STP_ERR_CNT,
    input  logic              clr_cnt
);
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              push;
    logic              pop;

    assign rd.RD_VALID = (FIFO_COUNT != '0);
    assign FULL        = (FIFO_COUNT == CNT_FULL);
    assign rd.RD_DATA  = mem[rd_ptr];

    assign pop  = rd.RD_VALID & rd.RD_READY;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push = data_Valid & (~FULL | pop);

    always_ff @(posedge clk_RX) begin
        if (push)
            mem[wr_ptr] <= P_DATA;
    end

    // Pointer width equals log2(DEPTH), so natural rollover is the wrap.
    always_ff @(posedge clk_RX or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            FIFO_COUNT <= '0;
            OVERFLOW   <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)
                FIFO_COUNT <= FIFO_COUNT + CNT_ONE;
            else if (pop && !push)
                FIFO_COUNT <= FIFO_COUNT - CNT_ONE;
            if (data_Valid && FULL && !pop)
                OVERFLOW <= 1'b1;
            else if (clr_ovf)
                OVERFLOW <= 1'b0;
        end
    end

    err_event_cnt #(.CNT_W(CNT_W)) u_par_cnt (
        .clk  (clk_RX),
        .rst  (rst),
        .flag (Parity_Error),
        .clr  (clr_cnt),
        .cnt  (PAR_ERR_CNT)
    );

    err_event_cnt #(.CNT_W(CNT_W)) u_stp_cnt (
        .clk  (clk_RX),
        .rst  (rst),
        .flag (Stop_Error),
        .clr  (clr_cnt),
        .cnt  (STP_ERR_CNT)
    );
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: FWFT data path, full/overflow edges, error counters, async reset.
module tb_uart_rx_fifo;
    logic       clk_RX;
    logic       rst;
    logic [7:0] P_DATA;
    logic       data_Valid;
    logic       Parity_Error;
    logic       Stop_Error;
    logic [3:0] FIFO_COUNT;
    logic       FULL;
    logic       OVERFLOW;
    logic       clr_ovf;
    logic [7:0] PAR_ERR_CNT;
    logic [7:0] STP_ERR_CNT;
    logic       clr_cnt;

    uart_rx_fifo_if rd_if ();

    uart_rx_fifo #(.DEPTH(8), .ADDR_W(3), .CNT_W(8)) dut (
        .clk_RX       (clk_RX),
        .rst          (rst),
        .P_DATA       (P_DATA),
        .data_Valid   (data_Valid),
        .Parity_Error (Parity_Error),
        .Stop_Error   (Stop_Error),
        .rd           (rd_if),
        .FIFO_COUNT   (FIFO_COUNT),
        .FULL         (FULL),
        .OVERFLOW     (OVERFLOW),
        .clr_ovf      (clr_ovf),
        .PAR_ERR_CNT  (PAR_ERR_CNT),
        .STP_ERR_CNT  (STP_ERR_CNT),
        .clr_cnt      (clr_cnt)
    );

    initial clk_RX = 1'b0;
    always #5 clk_RX = ~clk_RX;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_RX);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        P_DATA     = b;
        data_Valid = 1'b1;
        tick();
        data_Valid = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] exp);
        check({tag, "_valid"}, {31'd0, rd_if.RD_VALID}, 32'd1);
        check({tag, "_data"}, {24'd0, rd_if.RD_DATA}, {24'd0, exp});
        rd_if.RD_READY = 1'b1;
        tick();
        rd_if.RD_READY = 1'b0;
    endtask

    logic [7:0] q[$];
    int         mcnt;
    logic       m_pop;
    logic       m_push;

    initial begin
        rst            = 1'b1;
        P_DATA         = 8'h00;
        data_Valid     = 1'b0;
        Parity_Error   = 1'b0;
        Stop_Error     = 1'b0;
        clr_ovf        = 1'b0;
        clr_cnt        = 1'b0;
        rd_if.RD_READY = 1'b0;
        repeat (2) @(posedge clk_RX);
        #1;
        rst = 1'b0;

        check("rst_valid", {31'd0, rd_if.RD_VALID}, 32'd0);
        check("rst_count", {28'd0, FIFO_COUNT}, 32'd0);
        check("rst_full", {31'd0, FULL}, 32'd0);
        check("rst_ovf", {31'd0, OVERFLOW}, 32'd0);
        check("rst_par", {24'd0, PAR_ERR_CNT}, 32'd0);
        check("rst_stp", {24'd0, STP_ERR_CNT}, 32'd0);

        // Ready while empty must not disturb anything.
        rd_if.RD_READY = 1'b1;
        tick();
        rd_if.RD_READY = 1'b0;
        check("empty_rdy_count", {28'd0, FIFO_COUNT}, 32'd0);

        push_byte(8'hA5);
        check("single_valid", {31'd0, rd_if.RD_VALID}, 32'd1);
        check("single_data", {24'd0, rd_if.RD_DATA}, 32'hA5);
        check("single_count", {28'd0, FIFO_COUNT}, 32'd1);
        rd_if.RD_READY = 1'b1;
        tick();
        rd_if.RD_READY = 1'b0;
        check("single_pop_valid", {31'd0, rd_if.RD_VALID}, 32'd0);
        check("single_pop_count", {28'd0, FIFO_COUNT}, 32'd0);

        for (int i = 0; i < 8; i++) push_byte(8'(i));
        check("fill_full", {31'd0, FULL}, 32'd1);
        check("fill_count", {28'd0, FIFO_COUNT}, 32'd8);
        check("fill_ovf", {31'd0, OVERFLOW}, 32'd0);
        push_byte(8'hFF);
        check("drop_ovf", {31'd0, OVERFLOW}, 32'd1);
        check("drop_count", {28'd0, FIFO_COUNT}, 32'd8);

        // A drop coinciding with clr_ovf keeps the flag set.
        clr_ovf = 1'b1;
        push_byte(8'hEE);
        clr_ovf = 1'b0;
        check("clr_vs_drop_ovf", {31'd0, OVERFLOW}, 32'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("clr_ovf", {31'd0, OVERFLOW}, 32'd0);

        for (int i = 0; i < 8; i++) pop_expect("drain", 8'(i));
        check("drain_count", {28'd0, FIFO_COUNT}, 32'd0);
        check("drain_valid", {31'd0, rd_if.RD_VALID}, 32'd0);

        for (int i = 0; i < 8; i++) push_byte(8'h10 + 8'(i));
        P_DATA         = 8'h3C;
        data_Valid     = 1'b1;
        rd_if.RD_READY = 1'b1;
        tick();
        data_Valid     = 1'b0;
        rd_if.RD_READY = 1'b0;
        check("full_pp_count", {28'd0, FIFO_COUNT}, 32'd8);
        check("full_pp_ovf", {31'd0, OVERFLOW}, 32'd0);
        check("full_pp_head", {24'd0, rd_if.RD_DATA}, 32'h11);
        for (int i = 1; i < 8; i++) pop_expect("pp_drain", 8'h10 + 8'(i));
        pop_expect("pp_tail", 8'h3C);
        check("pp_drain_count", {28'd0, FIFO_COUNT}, 32'd0);

        // Interleaved traffic against a queue model; 20 pushes wrap the ring twice.
        mcnt = 0;
        for (int i = 0; i < 20; i++) begin
            P_DATA         = 8'h40 + 8'(i);
            data_Valid     = 1'b1;
            rd_if.RD_READY = (mcnt >= 4) || (i % 3 == 2);
            m_pop  = rd_if.RD_READY && (q.size() > 0);
            m_push = (q.size() < 8) || m_pop;
            if (m_pop) check("il_head", {24'd0, rd_if.RD_DATA}, {24'd0, q[0]});
            if (m_pop) void'(q.pop_front());
            if (m_push) q.push_back(P_DATA);
            mcnt = q.size();
            tick();
            check("il_count", {28'd0, FIFO_COUNT}, 32'(mcnt));
        end
        data_Valid     = 1'b0;
        rd_if.RD_READY = 1'b0;
        while (q.size() > 0) pop_expect("il_drain", q.pop_front());
        check("il_empty", {28'd0, FIFO_COUNT}, 32'd0);

        Parity_Error = 1'b1;
        repeat (5) tick();
        Parity_Error = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            Parity_Error = 1'b1;
            tick();
            Parity_Error = 1'b0;
            repeat (2) tick();
        end
        check("par_cnt", {24'd0, PAR_ERR_CNT}, 32'd4);
        check("par_no_push", {28'd0, FIFO_COUNT}, 32'd0);

        for (int i = 0; i < 300; i++) begin
            Stop_Error = 1'b1;
            tick();
            Stop_Error = 1'b0;
            tick();
        end
        check("stp_sat", {24'd0, STP_ERR_CNT}, 32'd255);
        check("stp_par_kept", {24'd0, PAR_ERR_CNT}, 32'd4);

        clr_cnt      = 1'b1;
        Parity_Error = 1'b1;
        tick();
        clr_cnt      = 1'b0;
        Parity_Error = 1'b0;
        tick();
        check("clr_par", {24'd0, PAR_ERR_CNT}, 32'd0);
        check("clr_stp", {24'd0, STP_ERR_CNT}, 32'd0);

        for (int i = 0; i < 8; i++) push_byte(8'h80 + 8'(i));
        push_byte(8'h99);
        for (int i = 0; i < 3; i++) pop_expect("pre_rst", 8'h80 + 8'(i));
        Parity_Error = 1'b1;
        tick();
        Parity_Error = 1'b0;
        tick();
        check("pre_rst_count", {28'd0, FIFO_COUNT}, 32'd5);
        check("pre_rst_ovf", {31'd0, OVERFLOW}, 32'd1);
        check("pre_rst_par", {24'd0, PAR_ERR_CNT}, 32'd1);

        // Reset lands mid-cycle, well away from any clock edge.
        rd_if.RD_READY = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", {31'd0, rd_if.RD_VALID}, 32'd0);
        check("arst_count", {28'd0, FIFO_COUNT}, 32'd0);
        check("arst_full", {31'd0, FULL}, 32'd0);
        check("arst_ovf", {31'd0, OVERFLOW}, 32'd0);
        check("arst_par", {24'd0, PAR_ERR_CNT}, 32'd0);
        check("arst_stp", {24'd0, STP_ERR_CNT}, 32'd0);
        rd_if.RD_READY = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_count", {28'd0, FIFO_COUNT}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
